// File: rtl/variable_table_loader.sv
// variable_table_loader: serialises a packed truth assignment, received as a word stream over
// valid/ready, into one-bit-per-cycle writes on the variable table cluster's shared load port.
// Optional feature: define VARIABLE_TABLE_LOADER_CLEAR_EN to zero every table address before
// the assignment is written.
module variable_table_loader #(
    parameter int unsigned VARIABLE_ADDRESS_WIDTH = 11,
    parameter int unsigned WORD_WIDTH             = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [VARIABLE_ADDRESS_WIDTH:0]   num_vars_i,
    input  logic                              abort_i,
    input  logic                              word_valid_i,
    input  logic [WORD_WIDTH-1:0]             word_data_i,
    output logic                              word_ready_o,
    output logic                              axi_en_o,
    output logic                              axi_wr_en_o,
    output logic [VARIABLE_ADDRESS_WIDTH-1:0] axi_addr_o,
    output logic                              axi_data_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned AW   = VARIABLE_ADDRESS_WIDTH;
    localparam int unsigned BitW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [AW:0]      MaxVars = {1'b1, {AW{1'b0}}};
    localparam logic [BitW-1:0]  LastBit = BitW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWait,
        StShift,
        StDone
    } state_e;

    state_e                state_q;
    logic [AW:0]           count_q;
    logic [AW:0]           var_q;
    logic [BitW-1:0]       bit_q;
    logic [WORD_WIDTH-1:0] word_q;
    logic                  ready_q;
    logic                  en_q;
    logic                  wr_en_q;
    logic [AW-1:0]         addr_q;
    logic                  data_q;
    logic                  busy_q;
    logic                  done_q;

    logic [AW:0]     count_d;
    logic [AW:0]     var_inc;
    logic [BitW-1:0] bit_inc;
    logic            last_var;

    // Clamp the requested count and precompute counter increments.
    always_comb begin
        count_d  = (num_vars_i > MaxVars) ? MaxVars : num_vars_i;
        var_inc  = var_q + 1'b1;
        bit_inc  = bit_q + 1'b1;
        last_var = (var_q == count_q - 1'b1);
    end

    // Load FSM; output registers hold what the load port shows during the next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            count_q <= '0;
            var_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Strobes and the done pulse are single-cycle unless re-armed below.
            en_q    <= 1'b0;
            wr_en_q <= 1'b0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != StIdle && abort_i) begin
                state_q <= StIdle;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            count_q <= count_d;
                            var_q   <= '0;
                            if (count_d == '0) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                busy_q <= 1'b1;
`ifdef VARIABLE_TABLE_LOADER_CLEAR_EN
                                state_q <= StClear;
                                en_q    <= 1'b1;
                                wr_en_q <= 1'b1;
                                addr_q  <= '0;
`else
                                state_q <= StWait;
                                ready_q <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef VARIABLE_TABLE_LOADER_CLEAR_EN
                    StClear: begin
                        // var_q doubles as the sweep address until the sweep completes.
                        if (var_q[AW-1:0] == {AW{1'b1}}) begin
                            state_q <= StWait;
                            ready_q <= 1'b1;
                            var_q   <= '0;
                        end else begin
                            var_q   <= var_inc;
                            en_q    <= 1'b1;
                            wr_en_q <= 1'b1;
                            addr_q  <= var_inc[AW-1:0];
                        end
                    end
`endif
                    StWait: begin
                        if (word_valid_i) begin
                            word_q  <= word_data_i;
                            bit_q   <= '0;
                            state_q <= StShift;
                            ready_q <= 1'b0;
                            en_q    <= 1'b1;
                            wr_en_q <= 1'b1;
                            addr_q  <= var_q[AW-1:0];
                            data_q  <= word_data_i[0];
                        end
                    end
                    StShift: begin
                        // The strobe for (var_q, bit_q) is on the port this cycle.
                        if (last_var) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            var_q <= var_inc;
                            if (bit_q == LastBit) begin
                                state_q <= StWait;
                                ready_q <= 1'b1;
                            end else begin
                                bit_q   <= bit_inc;
                                en_q    <= 1'b1;
                                wr_en_q <= 1'b1;
                                addr_q  <= var_inc[AW-1:0];
                                data_q  <= word_q[bit_inc];
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign word_ready_o = ready_q;
    assign axi_en_o     = en_q;
    assign axi_wr_en_o  = wr_en_q;
    assign axi_addr_o   = addr_q;
    assign axi_data_o   = data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_variable_table_loader.sv
// Scoreboard bench for variable_table_loader: stimulus pushes expected load-port writes and done
// pulses into a queue; a negedge monitor pops and compares whenever the DUT strobes.
module tb_variable_table_loader;

    localparam int AW = 11;
    localparam int WW = 32;
    localparam int NV = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   nvars = '0;
    logic          abort = 1'b0;
    logic          wvalid = 1'b0;
    logic [WW-1:0] wdata = '0;
    logic          ready, en, wr, data, busy, done;
    logic [AW-1:0] addr;

    variable_table_loader #(
        .VARIABLE_ADDRESS_WIDTH(AW),
        .WORD_WIDTH            (WW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .num_vars_i  (nvars),
        .abort_i     (abort),
        .word_valid_i(wvalid),
        .word_data_i (wdata),
        .word_ready_o(ready),
        .axi_en_o    (en),
        .axi_wr_en_o (wr),
        .axi_addr_o  (addr),
        .axi_data_o  (data),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_done;
        logic [AW-1:0] addr;
        logic          data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            t_start, h_first, h_last;
    logic [WW-1:0] word_tab[64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (en) begin
            check("strobe_wr_en", wr, 1);
            check("strobe_ready_low", ready, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got addr %0d data %0d expected none", addr, data);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_kind", 0, mon_e.is_done);
                check("strobe_addr", addr, mon_e.addr);
                check("strobe_data", data, mon_e.data);
            end
        end
        if (done) begin
            check("done_busy_low", busy, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done expected none");
            end else begin
                mon_e = sb.pop_front();
                check("done_kind", 1, mon_e.is_done);
            end
        end
    end

    // Queue the expected writes of a load of n variables, data strobes limited to lim.
    task automatic push_exp(input int n, input int lim, input bit with_done);
        int            eff;
        logic [WW-1:0] w;
        exp_t          e;
        eff = (n > NV) ? NV : n;
        if (eff > 0) begin
`ifdef VARIABLE_TABLE_LOADER_CLEAR_EN
            for (int a = 0; a < NV; a++) begin
                e = '{is_done: 1'b0, addr: a[AW-1:0], data: 1'b0};
                sb.push_back(e);
            end
`endif
            for (int v = 0; v < eff && v < lim; v++) begin
                w = word_tab[v / WW];
                e = '{is_done: 1'b0, addr: v[AW-1:0], data: w[v % WW]};
                sb.push_back(e);
            end
        end
        if (with_done) begin
            e = '{is_done: 1'b1, addr: '0, data: 1'b0};
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        nvars = n[AW:0];
        t_start = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present a word and hold it until the handshake edge; returns 1ns after that edge.
    task automatic send_word(input logic [WW-1:0] w);
        bit got;
        wvalid = 1'b1;
        wdata = w;
        got = 0;
        for (int c = 0; c < 6000; c++) begin
            if (ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready 0 expected 1");
        end
        h_last = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input bit poke);
        int eff, nw, blast, d;
        bit got;
        eff = (n > NV) ? NV : n;
        push_exp(n, NV, 1);
        do_start(n);
        check("busy_after_start", busy, (eff != 0));
`ifndef VARIABLE_TABLE_LOADER_CLEAR_EN
        check("ready_after_start", ready, (eff != 0));
`endif
        nw = (eff + WW - 1) / WW;
        blast = eff - WW * (nw - 1);
        for (int i = 0; i < nw; i++) begin
            send_word(word_tab[i]);
            if (i == 0) begin
                h_first = h_last;
                if (poke) begin
                    // A start while shifting must be ignored.
                    start = 1'b1;
                    nvars = '0;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        end
        wvalid = 1'b0;
        got = 0;
        d = 0;
        for (int c = 0; c < 6000; c++) begin
            if (done) begin
                got = 1;
                d = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done 0 expected 1");
        end else if (eff == 0) begin
            check("zero_done_latency", d - t_start, 1);
        end else begin
            check("done_latency", d - h_last, blast + 1);
            if (eff == 64) check("two_word_total", d - h_first, 66);
        end
        @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_en", en, 0);
        check("rst_wr", wr, 0);
        check("rst_addr", addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        // count=5, word 0x16 -> data 0,1,1,0,1
        word_tab[0] = 32'h0000_0016;
        load(5, 0);

        // count=64, valid held high, stray start ignored mid-shift
        word_tab[0] = 32'hFFFF_FFFF;
        word_tab[1] = 32'h0000_0001;
        load(64, 1);

        // count=0
        load(0, 0);

        // word_valid in IDLE is ignored
        wvalid = 1'b1;
        wdata = 32'hDEAD_BEEF;
        repeat (4) begin
            @(negedge clk);
            check("idle_ready_low", ready, 0);
        end
        wvalid = 1'b0;

        // count=4095 clamps to 2048; only address 2047 carries a 1
        for (int i = 0; i < 64; i++) word_tab[i] = '0;
        word_tab[63] = 32'h8000_0000;
        load(4095, 0);

        // abort at the 10th strobe of count=32
        word_tab[0] = 32'hA5A5_A5A5;
        push_exp(32, 10, 0);
        do_start(32);
        send_word(word_tab[0]);
        wvalid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_en", en, 0);
        check("abort_done", done, 0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_sb", sb.size(), 0);

        // new start after abort
        word_tab[0] = 32'h0000_0007;
        load(3, 0);

        // reset mid-shift: four strobes seen, then outputs cleared at once
        word_tab[0] = 32'hFFFF_FFFF;
        push_exp(32, 4, 0);
        do_start(32);
        send_word(word_tab[0]);
        wvalid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre_rst_en", en, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_en", en, 0);
        check("rst_mid_wr", wr, 0);
        check("rst_mid_addr", addr, 0);
        check("rst_mid_data", data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", ready, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_sb", sb.size(), 0);

        word_tab[0] = 32'h0000_0016;
        load(5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
